kbd_fifo: RTL and testbench

//   Keyboard input buffer directly upstream of the cpu input port.
//   - Captures 8-bit key codes on rising edges of a key strobe into a small FIFO.
//   - Presents the oldest code on the cpu `keyboard` bus and raises `en_inp`
//     (input flag) while any code is queued.
//   - Pops one entry per cpu input acknowledge, so keys typed faster than the

---
 rtl/kbd_fifo.sv | 76 +++++++
 tb/tb_kbd_fifo.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/kbd_fifo.sv
// Keyboard code buffer feeding the cpu input port: edge-detected key strobes enqueue, inp_ack dequeues.
// Latency: strobe rising before edge N is written at edge N+1; a pop is visible the cycle after its ack edge.
// Backpressure: none upstream; a strobe edge while full is dropped and latches the sticky overflow flag.
module kbd_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clkin,
    input  logic          rst,
    input  logic [DW-1:0] key_in,
    input  logic          key_stb,
    input  logic          inp_ack,
    input  logic          ovf_clr,
    output logic [DW-1:0] keyboard,
    output logic          en_inp,
    output logic [AW:0]   count,
    output logic          overflow
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          stb_q;
    logic          push_q;
    logic [DW-1:0] key_q;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = inp_ack & ~empty;
    // A full FIFO still accepts the push when the same edge pops an entry.
    assign do_push = push_q & (~full | do_pop);

    assign keyboard = empty ? '0 : mem[rd_ptr];
    assign en_inp   = ~empty;

    // Storage and the captured code are deliberately left out of reset.
    always_ff @(posedge clkin) begin
        if (key_stb & ~stb_q)
            key_q <= key_in;
        if (do_push)
            mem[wr_ptr] <= key_q;
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            stb_q    <= 1'b1;
            push_q   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            stb_q  <= key_stb;
            push_q <= key_stb & ~stb_q;
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_q & ~do_push)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kbd_fifo.sv
// Self-checking bench for kbd_fifo: vector table plus hand-written corner sequences, scoreboard-checked pops.
module tb_kbd_fifo;

    logic       clkin = 1'b0;
    logic       rst;
    logic [7:0] key_in;
    logic       key_stb;
    logic       inp_ack;
    logic       ovf_clr;
    logic [7:0] keyboard;
    logic       en_inp;
    logic [2:0] count;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [$];

    kbd_fifo #(.DW(8), .DEPTH(4), .AW(2)) dut (
        .clkin(clkin), .rst(rst), .key_in(key_in), .key_stb(key_stb),
        .inp_ack(inp_ack), .ovf_clr(ovf_clr), .keyboard(keyboard),
        .en_inp(en_inp), .count(count), .overflow(overflow)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        bit         is_ack;
        logic [7:0] code;
        logic [2:0] exp_count;
        logic [7:0] exp_kb;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe a code; returns after the entry would be written (two edges).
    task automatic strobe(input logic [7:0] code);
        key_in  = code;
        key_stb = 1'b1;
        @(negedge clkin);
        key_stb = 1'b0;
        key_in  = 8'hxx;
        @(negedge clkin);
        if (sb.size() < 4)
            sb.push_back(code);
    endtask

    // Ack the head; compares the consumed code with the scoreboard first.
    task automatic ack(input string name);
        logic [7:0] exp;
        exp = (sb.size() != 0) ? sb.pop_front() : 8'h00;
        check(name, keyboard, exp);
        inp_ack = 1'b1;
        @(negedge clkin);
        inp_ack = 1'b0;
    endtask

    task automatic state(input string name, input logic [2:0] c, input logic [7:0] kb, input logic ov);
        check({name, ".count"}, count, c);
        check({name, ".en_inp"}, en_inp, c != 0);
        check({name, ".keyboard"}, keyboard, kb);
        check({name, ".overflow"}, overflow, ov);
    endtask

    initial begin
        vecs[0] = '{0, 8'h99, 3'd1, 8'h99, 1'b0};
        vecs[1] = '{0, 8'h77, 3'd2, 8'h99, 1'b0};
        vecs[2] = '{0, 8'h88, 3'd3, 8'h99, 1'b0};
        vecs[3] = '{0, 8'hEE, 3'd4, 8'h99, 1'b0};
        vecs[4] = '{1, 8'h00, 3'd3, 8'h77, 1'b0};
        vecs[5] = '{1, 8'h00, 3'd2, 8'h88, 1'b0};
        vecs[6] = '{1, 8'h00, 3'd1, 8'hEE, 1'b0};
        vecs[7] = '{1, 8'h00, 3'd0, 8'h00, 1'b0};
        vecs[8] = '{1, 8'h00, 3'd0, 8'h00, 1'b0};

        key_in = 8'h00; inp_ack = 0; ovf_clr = 0;

        // 1: strobe held high through reset must not enqueue
        rst = 1'b1; key_stb = 1'b1;
        repeat (2) @(negedge clkin);
        rst = 1'b0;
        repeat (3) @(negedge clkin);
        state("reset", 3'd0, 8'h00, 1'b0);
        key_stb = 1'b0;
        @(negedge clkin);

        // 2: latency of a single code, then pop
        key_in = 8'h77; key_stb = 1'b1;
        @(negedge clkin);
        check("lat.en_early", en_inp, 1'b0);
        key_stb = 1'b0;
        @(negedge clkin);
        sb.push_back(8'h77);
        state("single", 3'd1, 8'h77, 1'b0);
        ack("single.pop");
        state("single.after", 3'd0, 8'h00, 1'b0);

        // 3: ordered drain, twice for pointer wrap; last ack hits an empty FIFO
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 9; i++) begin
                if (vecs[i].is_ack) ack($sformatf("tbl%0d.%0d.pop", rep, i));
                else                strobe(vecs[i].code);
                state($sformatf("tbl%0d.%0d", rep, i), vecs[i].exp_count, vecs[i].exp_kb, vecs[i].exp_ovf);
            end
        end

        // held strobe yields one push
        key_in = 8'h5A; key_stb = 1'b1;
        repeat (6) @(negedge clkin);
        key_stb = 1'b0;
        @(negedge clkin);
        sb.push_back(8'h5A);
        state("held", 3'd1, 8'h5A, 1'b0);
        ack("held.pop");

        // 4: overflow on full
        strobe(8'hA1); strobe(8'hA2); strobe(8'hA3); strobe(8'hA4);
        strobe(8'h11);
        state("ovf", 3'd4, 8'hA1, 1'b1);
        ovf_clr = 1'b1;
        @(negedge clkin);
        ovf_clr = 1'b0;
        state("ovf.clr", 3'd4, 8'hA1, 1'b0);
        // overflow set wins over a same-cycle clear
        key_in = 8'h12; key_stb = 1'b1;
        @(negedge clkin);
        key_stb = 1'b0; ovf_clr = 1'b1;
        @(negedge clkin);
        ovf_clr = 1'b0;
        state("ovf.setwins", 3'd4, 8'hA1, 1'b1);
        ovf_clr = 1'b1;
        @(negedge clkin);
        ovf_clr = 1'b0;

        // 5: full, push 22 with simultaneous ack
        key_in = 8'h22; key_stb = 1'b1;
        @(negedge clkin);
        key_stb = 1'b0; inp_ack = 1'b1;
        @(negedge clkin);
        inp_ack = 1'b0;
        void'(sb.pop_front());
        sb.push_back(8'h22);
        state("fullpp", 3'd4, 8'hA2, 1'b0);
        repeat (4) ack("fullpp.drain");
        state("fullpp.empty", 3'd0, 8'h00, 1'b0);

        // 6: empty, push 33 with simultaneous ack
        key_in = 8'h33; key_stb = 1'b1;
        @(negedge clkin);
        key_stb = 1'b0; inp_ack = 1'b1;
        @(negedge clkin);
        inp_ack = 1'b0;
        sb.push_back(8'h33);
        state("emptypp", 3'd1, 8'h33, 1'b0);
        ack("emptypp.pop");
        ack("emptyack");
        state("emptyack", 3'd0, 8'h00, 1'b0);

        // reset mid-operation discards queued codes
        strobe(8'h44); strobe(8'h55);
        state("prerst", 3'd2, 8'h44, 1'b0);
        rst = 1'b1;
        @(negedge clkin);
        rst = 1'b0;
        sb.delete();
        @(negedge clkin);
        state("midrst", 3'd0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
